// File: rtl/audio_dsp_pkg.sv
// Shared types and helpers for the audio DSP blocks (echo/delay processor and friends).
package audio_dsp_pkg;

  typedef enum logic [1:0] {IDLE, RD, MAC, WR} echo_state_t;

  // Offset-binary midscale for a DW-bit sample.
  function automatic int MIDSCALE(input int dw);
    return 1 << (dw - 1);
  endfunction

  // Clamp a signed value into the range of a w-bit two's-complement number.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/echo_delay_proc_if.sv
// Sample-stream interface of the echo/delay processor: input strobe and controls, output strobe and flags.
interface echo_delay_proc_if #(
  parameter int DW = 10,
  parameter int AW = 13,
  parameter int GW = 4
);
  logic          din_valid;
  logic [DW-1:0] din;
  logic [AW-1:0] delay;
  logic [GW-1:0] gain;
  logic          mode;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          busy;
  logic          overrun;

  modport master (
    output din_valid, din, delay, gain, mode,
    input  dout, dout_valid, busy, overrun
  );

  modport slave (
    input  din_valid, din, delay, gain, mode,
    output dout, dout_valid, busy, overrun
  );
endinterface

// File: rtl/echo_ram.sv
// Single-port echo history buffer: DW x 2**AW, synchronous write, registered read.
module echo_ram #(
  parameter int DW = 10,
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [0:(1<<AW)-1];
  logic [DW-1:0] r_rdata;

  // NOTE: neither the array nor the read register is reset, so the tools can map this onto block RAM.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/echo_delay_proc.sv
// Echo/delay processor: single (FIR) or feedback (IIR) echo with gain/2**GW over a 2**AW-sample history.
// Define ECHO_SAT_EN to saturate the echo sum; otherwise it wraps in DW-bit two's complement.
module echo_delay_proc
  import audio_dsp_pkg::*;
#(
  parameter int DW = 10,
  parameter int AW = 13,
  parameter int GW = 4
) (
  input logic              sysclk,
  input logic              rst,
  echo_delay_proc_if.slave bus
);
  localparam logic [DW-1:0] MID = DW'(MIDSCALE(DW));
  localparam int            PW  = DW + GW + 1;

  echo_state_t r_state, w_next_state;

  logic signed [DW-1:0] r_x_s;
  logic        [AW-1:0] r_delay;
  logic        [GW-1:0] r_gain;
  logic                 r_mode;
  logic signed [DW-1:0] r_y_lim;
  logic        [AW-1:0] r_wr_ptr;
  logic        [AW-1:0] r_fill;
  logic        [DW-1:0] r_dout;
  logic                 r_dout_valid;
  logic                 r_overrun;

  logic        [AW-1:0] w_ram_addr;
  logic                 w_ram_we;
  logic        [DW-1:0] w_ram_wdata;
  logic        [DW-1:0] w_ram_rdata;
  logic                 w_echo_hit;
  logic signed [DW-1:0] w_d_s;
  logic signed [PW-1:0] w_prod;
  logic signed [DW-1:0] w_e;
  logic signed [DW:0]   w_y;
  logic signed [DW-1:0] w_y_lim;

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: if (bus.din_valid) w_next_state = RD;
      RD:   w_next_state = MAC;
      MAC:  w_next_state = WR;
      WR:   w_next_state = IDLE;
    endcase
  end

  // Per-sample operands: captured once in IDLE, so mid-sample control changes are ignored.
  always_ff @(posedge sysclk) begin
    if (r_state == IDLE && bus.din_valid) begin
      r_x_s   <= bus.din - MID;
      r_delay <= bus.delay;
      r_gain  <= bus.gain;
      r_mode  <= bus.mode;
    end
    if (r_state == MAC) r_y_lim <= w_y_lim;
  end

  assign w_ram_we    = (r_state == WR);
  assign w_ram_addr  = w_ram_we ? r_wr_ptr : r_wr_ptr - r_delay;
  assign w_ram_wdata = r_mode ? r_y_lim : r_x_s;

  echo_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk     (sysclk),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  // The fill count hides stale RAM contents left over from before reset.
  assign w_echo_hit = (r_delay != '0) && (r_delay <= r_fill);
  assign w_d_s      = w_echo_hit ? $signed(w_ram_rdata) : '0;
  assign w_prod     = PW'(w_d_s) * PW'($signed({1'b0, r_gain}));
  assign w_e        = DW'(w_prod >>> GW);
  assign w_y        = (DW+1)'(r_x_s) + (DW+1)'(w_e);

`ifdef ECHO_SAT_EN
  assign w_y_lim = DW'(sat_signed(32'(w_y), DW));
`else
  assign w_y_lim = DW'(w_y);
`endif

  // dout loads on the MAC->WR edge so it is already valid during the dout_valid cycle.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_fill       <= '0;
      r_dout       <= MID;
      r_dout_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_dout_valid <= (r_state == MAC);
      if (r_state == MAC) r_dout <= $unsigned(w_y_lim) + MID;
      if (r_state == WR) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        if (~&r_fill) r_fill <= r_fill + AW'(1);
      end
      if (bus.din_valid && r_state != IDLE) r_overrun <= 1'b1;
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.busy       = (r_state != IDLE);
  assign bus.overrun    = r_overrun;
endmodule
